muldiv_seq: RTL and testbench

- Multi-cycle MULTU/DIVU sequencer that reuses the shared 32-bit combinational ALU.
- Its add/subtract path performs one shift-add (multiply) or one restoring-division step per cycle.
- Sits beside the EX stage. While busy_o is high, the EX-stage ALU input mux grants the ALU to this block; the pipeline stalls.
- Results commit to HI/LO registers, which are read by MFHI/MFLO.

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/muldiv_seq_step.sv | 56 +++++
 rtl/muldiv_seq.sv | 128 ++++++++++++
 tb/tb_muldiv_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the multi-cycle MULTU/DIVU sequencer: ALU control codes,
// muldiv op codes and FSM state encodings.
package muldiv_seq_pkg;

  // ALU control codes understood by the shared combinational ALU
  localparam int unsigned ALU_AND   = 0;
  localparam int unsigned ALU_OR    = 1;
  localparam int unsigned ALU_NAND  = 2;
  localparam int unsigned ALU_NOR   = 3;
  localparam int unsigned ALU_ADDU  = 4;
  localparam int unsigned ALU_SUBU  = 5;
  localparam int unsigned ALU_SLT   = 6;
  localparam int unsigned ALU_EQUAL = 7;
  localparam int unsigned ALU_SRA   = 8;
  localparam int unsigned ALU_SRAV  = 9;
  localparam int unsigned ALU_LUI   = 10;
  localparam int unsigned ALU_SLTU  = 11;

  // muldiv operation select
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring divide, built around the
// shared ALU: drives the ALU operands and forms the next working HI/LO.
module muldiv_seq_step
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CTRL_ADDU  = ALU_ADDU,
  parameter int unsigned CTRL_SUBU  = ALU_SUBU
) (
  input  logic [DATA_W-1:0]     w_hi,
  input  logic [DATA_W-1:0]     w_lo,
  input  logic [DATA_W-1:0]     w_op,
  input  logic                  op,
  input  logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     alu_src1,
  output logic [DATA_W-1:0]     alu_src2,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [DATA_W-1:0]     hi_nxt,
  output logic [DATA_W-1:0]     lo_nxt
);

  logic [DATA_W-1:0] rem_shift;
  logic              ge;
  logic              carry;

  // Multiply: add multiplicand when LSB set, shift {carry,sum,lo} right.
  // Divide: shift remainder left, subtract divisor when it fits.
  always_comb begin
    rem_shift = {w_hi[DATA_W-2:0], w_lo[DATA_W-1]};
    ge        = 1'b0;
    carry     = 1'b0;
    alu_src1  = w_hi;
    alu_src2  = '0;
    alu_ctrl  = ALU_CTRL_W'(CTRL_ADDU);
    hi_nxt    = w_hi;
    lo_nxt    = w_lo;
    if (op == OP_DIVU) begin
      alu_src1 = rem_shift;
      alu_src2 = w_op;
      alu_ctrl = ALU_CTRL_W'(CTRL_SUBU);
      // the bit shifted out of the remainder makes the 33-bit value >= divisor
      ge       = w_hi[DATA_W-1] | ~(rem_shift < w_op);
      hi_nxt   = ge ? alu_result : rem_shift;
      lo_nxt   = {w_lo[DATA_W-2:0], ge};
    end else begin
      alu_src1 = w_hi;
      alu_src2 = w_lo[0] ? w_op : '0;
      alu_ctrl = ALU_CTRL_W'(CTRL_ADDU);
      // an unsigned add wrapped iff the sum is below an operand
      carry    = alu_result < w_hi;
      {hi_nxt, lo_nxt} = {carry, alu_result, w_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer borrowing the EX-stage ALU while busy;
// commits results to HI/LO.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CTRL_ADDU  = ALU_ADDU,
  parameter int unsigned CTRL_SUBU  = ALU_SUBU
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  op_i,
  input  logic [DATA_W-1:0]     rs_i,
  input  logic [DATA_W-1:0]     rt_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic [DATA_W-1:0]     alu_src1_o,
  output logic [DATA_W-1:0]     alu_src2_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0]     alu_result_i
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_W-1:0]     w_hi;
  logic [DATA_W-1:0]     w_lo;
  logic [DATA_W-1:0]     w_op;
  logic                  w_div;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  div_zero;
  logic                  last_step;
  logic [DATA_W-1:0]     step_src1;
  logic [DATA_W-1:0]     step_src2;
  logic [ALU_CTRL_W-1:0] step_ctrl;
  logic [DATA_W-1:0]     hi_nxt;
  logic [DATA_W-1:0]     lo_nxt;

  assign accept    = (state == ST_IDLE) && start_i && !flush_i;
  assign div_zero  = (op_i == OP_DIVU) && (rt_i == '0);
  assign last_step = (state == ST_RUN) && !flush_i && (cnt == CNT_W'(DATA_W - 1));

  muldiv_seq_step #(
    .DATA_W     (DATA_W),
    .ALU_CTRL_W (ALU_CTRL_W),
    .CTRL_ADDU  (CTRL_ADDU),
    .CTRL_SUBU  (CTRL_SUBU)
  ) u_step (
    .w_hi       (w_hi),
    .w_lo       (w_lo),
    .w_op       (w_op),
    .op         (w_div),
    .alu_result (alu_result_i),
    .alu_src1   (step_src1),
    .alu_src2   (step_src2),
    .alu_ctrl   (step_ctrl),
    .hi_nxt     (hi_nxt),
    .lo_nxt     (lo_nxt)
  );

  // ALU is only driven by the step logic while we hold the grant
  assign alu_src1_o = (state == ST_RUN) ? step_src1 : '0;
  assign alu_src2_o = (state == ST_RUN) ? step_src2 : '0;
  assign alu_ctrl_o = (state == ST_RUN) ? step_ctrl : ALU_CTRL_W'(CTRL_ADDU);

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)         state_nxt = div_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (flush_i)        state_nxt = ST_IDLE;
               else if (last_step) state_nxt = ST_DONE;
      ST_DONE:                     state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Working registers, counter, status flags and HI/LO commit
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      w_op   <= '0;
      w_div  <= 1'b0;
      cnt    <= '0;
    end else begin
      busy_o <= (state_nxt == ST_RUN);
      done_o <= (state_nxt == ST_DONE);
      if (accept) begin
        w_op  <= (op_i == OP_DIVU) ? rt_i : rs_i;
        w_lo  <= (op_i == OP_DIVU) ? rs_i : rt_i;
        w_hi  <= '0;
        w_div <= op_i;
        cnt   <= '0;
        if (div_zero) begin
          hi_o <= rs_i;
          lo_o <= '1;
        end
      end else if (state == ST_RUN) begin
        w_hi <= hi_nxt;
        w_lo <= lo_nxt;
        cnt  <= cnt + CNT_W'(1);
        if (last_step) begin
          hi_o <= hi_nxt;
          lo_o <= lo_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        op_i = 1'b0;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  // shared ALU: only the add/subtract codes matter here
  assign alu_result_i = (alu_ctrl_o == 4'd4) ? alu_src1_o + alu_src2_o :
                        (alu_ctrl_o == 4'd5) ? alu_src1_o - alu_src2_o : 32'd0;

  muldiv_seq dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .op_i         (op_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i)
  );

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_done;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE; cycle k is the k-th negedge after the accept edge
  task automatic run_op(input logic op, input logic [31:0] rs, input logic [31:0] rt,
                        output int done_cyc, output int busy_cnt,
                        output logic ctrl_ok, output logic stable_ok, output logic pulse_ok);
    logic [31:0] hi0, lo0;
    logic [3:0]  exp_ctrl;
    done_cyc  = 0;
    busy_cnt  = 0;
    ctrl_ok   = 1'b1;
    stable_ok = 1'b1;
    pulse_ok  = 1'b0;
    exp_ctrl  = op ? 4'd5 : 4'd4;
    @(negedge clk_i);
    hi0 = hi_o;
    lo0 = lo_o;
    start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk_i);
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (busy_o) begin
        busy_cnt++;
        if (alu_ctrl_o !== exp_ctrl) ctrl_ok = 1'b0;
        if (hi_o !== hi0 || lo_o !== lo0) stable_ok = 1'b0;
      end
    end
    @(negedge clk_i);
    pulse_ok = !done_o && !busy_o;
  endtask

  int          dc, bc;
  logic        c_ok, s_ok, p_ok;
  int          busy_seen;
  logic        done_seen;

  initial begin
    vecs[0] = '{"mul_7x6",    1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A, 33, 32};
    vecs[1] = '{"mul_max",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 32};
    vecs[2] = '{"mul_2^31x2", 1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 33, 32};
    vecs[3] = '{"div_100_7",  1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        33, 32};
    vecs[4] = '{"div_max_1",  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 33, 32};
    vecs[5] = '{"div_max_max",1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 33, 32};
    vecs[6] = '{"div_5_10",   1'b1, 32'd5,         32'd10,        32'd5,         32'd0,         33, 32};
    vecs[7] = '{"div_by_0",   1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1,  0};

    // reset values
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_src1", alu_src1_o, 32'd0);
    chk("rst_src2", alu_src2_o, 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl_o), 32'd4);
    @(negedge clk_i);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, dc, bc, c_ok, s_ok, p_ok);
      chk({vecs[i].name, "_hi"}, hi_o, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo_o, vecs[i].exp_lo);
      chk({vecs[i].name, "_done_cyc"}, 32'(dc), 32'(vecs[i].exp_done));
      chk({vecs[i].name, "_busy_cyc"}, 32'(bc), 32'(vecs[i].exp_busy));
      chk({vecs[i].name, "_ctrl"}, 32'(c_ok), 32'd1);
      chk({vecs[i].name, "_stable"}, 32'(s_ok), 32'd1);
      chk({vecs[i].name, "_pulse"}, 32'(p_ok), 32'd1);
    end

    // flush mid-run: commit 0/0x2A first, then abort a run; a stray start is ignored
    run_op(1'b0, 32'd7, 32'd6, dc, bc, c_ok, s_ok, p_ok);
    chk("pre_flush_lo", lo_o, 32'h2A);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 1'b0; rs_i = 32'd3; rt_i = 32'd5;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    busy_seen = 0;
    done_seen = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk_i);
      if (busy_o) busy_seen++;
      if (done_o) done_seen = 1'b1;
      start_i = (cyc == 5);
      op_i    = (cyc == 5);
      rs_i    = 32'h0BAD_0BAD;
      rt_i    = 32'd0;
      flush_i = (cyc == 10);
    end
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_busy_cyc", 32'(busy_seen), 32'd10);
    chk("flush_no_done", 32'(done_seen), 32'd0);
    chk("flush_hi", hi_o, 32'd0);
    chk("flush_lo", lo_o, 32'h2A);
    chk("flush_idle_ctrl", 32'(alu_ctrl_o), 32'd4);

    // flush together with start in IDLE: not accepted
    start_i = 1'b1; flush_i = 1'b1; op_i = 1'b1; rs_i = 32'h55; rt_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", 32'(busy_o), 32'd0);
    chk("flush_start_done", 32'(done_o), 32'd0);
    chk("flush_start_lo", lo_o, 32'h2A);

    // start held through the DONE cycle: second request ignored
    start_i = 1'b1; op_i = 1'b1; rs_i = 32'h77; rt_i = 32'd0;
    @(negedge clk_i);
    chk("hold_done1", 32'(done_o), 32'd1);
    chk("hold_hi", hi_o, 32'h77);
    @(negedge clk_i);
    start_i = 1'b0;
    chk("hold_done2", 32'(done_o), 32'd0);
    chk("hold_busy2", 32'(busy_o), 32'd0);

    // asynchronous reset mid-run, then a fresh multiply
    @(negedge clk_i);
    start_i = 1'b1; op_i = 1'b0; rs_i = 32'd9; rt_i = 32'd9;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    run_op(1'b0, 32'd3, 32'd5, dc, bc, c_ok, s_ok, p_ok);
    chk("post_rst_lo", lo_o, 32'd15);
    chk("post_rst_hi", hi_o, 32'd0);
    chk("post_rst_done_cyc", 32'(dc), 32'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
